// File: rtl/dff_arb_pkg.sv
// rtl/dff_arb_pkg.sv - shared state encoding and reset constants for dff_bank_arbiter
package dff_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    // Per-bit reset values, replicated to the register width at the point of use.
    localparam logic Q_RST  = 1'b0;
    localparam logic QN_RST = 1'b1;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational rotate-and-priority-encode winner selection
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int OW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [OW-1:0]    ptr_i,
    output logic [OW-1:0]    winner_o,
    output logic             valid_o
);

    logic [OW-1:0] idx;

    // Scan from the far end back to ptr so the closest requester at or after ptr wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = OW'((int'(ptr_i) + k) % N_REQ);
            if (req_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin write arbiter for a shared WIDTH-bit Q/Q_n register
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_REQ = 4,
    localparam int OW    = $clog2(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] DATA,
    output logic [N_REQ-1:0]       GNT,
    output logic                   ACK,
    output logic [OW-1:0]          OWNER,
    output logic                   BUSY,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH-1:0]       Q_n
);

    arb_state_e       state_q, state_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qn_q, qn_d;

    logic [OW-1:0]    pick_winner;
    logic             pick_valid;
    logic [WIDTH-1:0] owner_data;
    logic             owner_req;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .OW    (OW)
    ) u_picker (
        .req_i    (REQ),
        .ptr_i    (ptr_q),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                owner_data = DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    assign owner_req = REQ[owner_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        ack_d   = 1'b0;
        q_d     = q_q;
        qn_d    = qn_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d              = '0;
                    gnt_d[pick_winner] = 1'b1;
                    owner_d            = pick_winner;
                    state_d            = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (owner_req) begin
                    q_d     = owner_data;
                    qn_d    = ~owner_data;
                    ack_d   = 1'b1;
                    ptr_d   = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
                    state_d = ST_WRITE;
                end else begin
                    // Owner withdrew before the write: drop the grant, keep the pointer.
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                gnt_d   = '0;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            q_q     <= {WIDTH{Q_RST}};
            qn_q    <= {WIDTH{QN_RST}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
            qn_q    <= qn_d;
        end
    end

    assign GNT   = gnt_q;
    assign ACK   = ack_q;
    assign OWNER = owner_q;
    assign BUSY  = busy_q;
    assign Q     = q_q;
    assign Q_n   = qn_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - randomized self-checking bench for dff_bank_arbiter
module tb_dff_bank_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [31:0] DATA;
    logic [3:0]  GNT;
    logic        ACK;
    logic [1:0]  OWNER;
    logic        BUSY;
    logic [7:0]  Q;
    logic [7:0]  Q_n;

    int n_cmp;
    int n_err;
    logic prev_ack;

    int         m_ptr;
    logic [7:0] m_q;
    int         m_owner;

    dff_bank_arbiter #(.WIDTH(8), .N_REQ(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .DATA  (DATA),
        .GNT   (GNT),
        .ACK   (ACK),
        .OWNER (OWNER),
        .BUSY  (BUSY),
        .Q     (Q),
        .Q_n   (Q_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int pick(input logic [3:0] m, input int p);
        int order[$];
        for (int k = 0; k < 4; k++) order.push_back((p + k) % 4);
        foreach (order[j]) if (m[order[j]]) return order[j];
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] slice(input logic [31:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    // Advance one edge, sample 1ns later, and check the always-true properties.
    task automatic tick();
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q_n !== ~Q) begin
            n_err++;
            $display("FAIL inv_qn: Q=%h Q_n=%h required Q_n=%h", Q, Q_n, ~Q);
        end
        n_cmp++;
        if (!$onehot0(GNT)) begin
            n_err++;
            $display("FAIL inv_gnt_onehot: GNT=%b required one-hot or zero", GNT);
        end
        n_cmp++;
        if (ACK === 1'b1 && prev_ack === 1'b1) begin
            n_err++;
            $display("FAIL inv_ack_pulse: ACK high two cycles in a row");
        end
        prev_ack = ACK;
    endtask

    task automatic do_reset();
        RST  = 1'b1;
        REQ  = '0;
        DATA = $urandom;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        prev_ack = 1'b0;
        m_ptr    = 0;
        m_q      = 8'h00;
        m_owner  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (Q !== 8'h00)     begin n_err++; $display("FAIL reset_q: got %h required 00", Q); end
        n_cmp++; if (Q_n !== 8'hFF)   begin n_err++; $display("FAIL reset_qn: got %h required ff", Q_n); end
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b required 0000", GNT); end
        n_cmp++; if (ACK !== 1'b0)    begin n_err++; $display("FAIL reset_ack: got %b required 0", ACK); end
        n_cmp++; if (OWNER !== 2'd0)  begin n_err++; $display("FAIL reset_owner: got %0d required 0", OWNER); end
        n_cmp++; if (BUSY !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b required 0", BUSY); end
    endtask

    task automatic test_single();
        do_reset();
        DATA = {24'h3C7E11, 8'hA5};
        REQ  = 4'b0001;
        tick();
        n_cmp++; if (GNT !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b required 0001", GNT); end
        n_cmp++; if (BUSY !== 1'b1)   begin n_err++; $display("FAIL single_busy: got %b required 1", BUSY); end
        n_cmp++; if (ACK !== 1'b0)    begin n_err++; $display("FAIL single_ack_early: got %b required 0", ACK); end
        tick();
        n_cmp++; if (Q !== 8'hA5)     begin n_err++; $display("FAIL single_q: got %h required a5", Q); end
        n_cmp++; if (Q_n !== 8'h5A)   begin n_err++; $display("FAIL single_qn: got %h required 5a", Q_n); end
        n_cmp++; if (ACK !== 1'b1)    begin n_err++; $display("FAIL single_ack: got %b required 1", ACK); end
        tick();
        n_cmp++; if (ACK !== 1'b0)    begin n_err++; $display("FAIL single_ack_drop: got %b required 0", ACK); end
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL single_gnt_drop: got %b required 0000", GNT); end
        repeat (3) begin
            tick();
            n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL single_busy_hold: got %b required 1", BUSY); end
        end
        REQ = 4'b0000;
        tick();
        n_cmp++; if (BUSY !== 1'b0)   begin n_err++; $display("FAIL single_busy_release: got %b required 0", BUSY); end
        n_cmp++; if (Q !== 8'hA5)     begin n_err++; $display("FAIL single_q_hold: got %h required a5", Q); end
        m_q   = 8'hA5;
        m_ptr = 1;
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        logic [31:0] d;
        do_reset();
        REQ = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            d    = $urandom;
            DATA = d;
            tick();
            n_cmp++; if (GNT !== onehot(order[n])) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b required %b", n, GNT, onehot(order[n])); end
            n_cmp++; if (OWNER !== 2'(order[n]))   begin n_err++; $display("FAIL rr_owner[%0d]: got %0d required %0d", n, OWNER, order[n]); end
            tick();
            n_cmp++; if (Q !== slice(d, order[n])) begin n_err++; $display("FAIL rr_q[%0d]: got %h required %h", n, Q, slice(d, order[n])); end
            n_cmp++; if (ACK !== 1'b1)             begin n_err++; $display("FAIL rr_ack[%0d]: got %b required 1", n, ACK); end
            REQ[order[n]] = 1'b0;
            tick();
            tick();
            n_cmp++; if (BUSY !== 1'b0)            begin n_err++; $display("FAIL rr_idle[%0d]: got %b required 0", n, BUSY); end
            REQ[order[n]] = 1'b1;
            m_q = slice(d, order[n]);
        end
        REQ   = 4'b0000;
        m_ptr = 1;
    endtask

    task automatic test_abort();
        int exp;
        logic [31:0] d;
        REQ  = 4'b0100;
        DATA = $urandom;
        tick();
        n_cmp++; if (GNT !== 4'b0100) begin n_err++; $display("FAIL abort_gnt: got %b required 0100", GNT); end
        REQ = 4'b0000;
        tick();
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL abort_gnt_drop: got %b required 0000", GNT); end
        n_cmp++; if (ACK !== 1'b0)    begin n_err++; $display("FAIL abort_ack: got %b required 0", ACK); end
        n_cmp++; if (Q !== m_q)       begin n_err++; $display("FAIL abort_q: got %h required %h", Q, m_q); end
        n_cmp++; if (BUSY !== 1'b0)   begin n_err++; $display("FAIL abort_busy: got %b required 0", BUSY); end
        exp  = pick(4'b1111, m_ptr);
        d    = $urandom;
        DATA = d;
        REQ  = 4'b1111;
        tick();
        n_cmp++; if (GNT !== onehot(exp)) begin n_err++; $display("FAIL abort_next_gnt: got %b required %b", GNT, onehot(exp)); end
        tick();
        n_cmp++; if (Q !== slice(d, exp)) begin n_err++; $display("FAIL abort_next_q: got %h required %h", Q, slice(d, exp)); end
        REQ = 4'b0000;
        tick();
        tick();
        m_q   = slice(d, exp);
        m_ptr = (exp + 1) % 4;
    endtask

    task automatic test_hold_release();
        logic [31:0] d;
        do_reset();
        d    = $urandom;
        DATA = d;
        REQ  = 4'b1010;
        tick();
        n_cmp++; if (GNT !== 4'b0010) begin n_err++; $display("FAIL hold_gnt1: got %b required 0010", GNT); end
        tick();
        n_cmp++; if (Q !== slice(d, 1)) begin n_err++; $display("FAIL hold_q1: got %h required %h", Q, slice(d, 1)); end
        tick();
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if (GNT !== 4'b0000 || OWNER !== 2'd1 || BUSY !== 1'b1) begin
                n_err++;
                $display("FAIL hold_wait[%0d]: got GNT=%b OWNER=%0d BUSY=%b required 0000/1/1", c, GNT, OWNER, BUSY);
            end
        end
        REQ = 4'b1000;
        tick();
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL hold_release_gnt: got %b required 0000", GNT); end
        tick();
        n_cmp++; if (GNT !== 4'b1000) begin n_err++; $display("FAIL hold_gnt3: got %b required 1000", GNT); end
        n_cmp++; if (OWNER !== 2'd3)  begin n_err++; $display("FAIL hold_owner3: got %0d required 3", OWNER); end
        tick();
        REQ = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        DATA = 32'h0000_003C;
        REQ  = 4'b0001;
        tick();
        tick();
        REQ = 4'b0000;
        tick();
        tick();
        n_cmp++; if (Q !== 8'h3C) begin n_err++; $display("FAIL arst_pre_q: got %h required 3c", Q); end
        DATA = 32'hFFFF_FFFF;
        REQ  = 4'b0001;
        tick();
        n_cmp++; if (GNT !== 4'b0001) begin n_err++; $display("FAIL arst_in_grant: got %b required 0001", GNT); end
        #2;
        RST = 1'b1;
        #1;
        n_cmp++; if (Q !== 8'h00)     begin n_err++; $display("FAIL arst_q: got %h required 00", Q); end
        n_cmp++; if (Q_n !== 8'hFF)   begin n_err++; $display("FAIL arst_qn: got %h required ff", Q_n); end
        n_cmp++; if (GNT !== 4'b0000) begin n_err++; $display("FAIL arst_gnt: got %b required 0000", GNT); end
        n_cmp++; if (ACK !== 1'b0)    begin n_err++; $display("FAIL arst_ack: got %b required 0", ACK); end
        n_cmp++; if (BUSY !== 1'b0 || OWNER !== 2'd0) begin
            n_err++;
            $display("FAIL arst_busy_owner: got BUSY=%b OWNER=%0d required 0/0", BUSY, OWNER);
        end
        REQ = 4'b0000;
        tick();
        RST = 1'b0;
        tick();
        n_cmp++; if (Q !== 8'h00 || ACK !== 1'b0) begin
            n_err++;
            $display("FAIL arst_no_write: got Q=%h ACK=%b required 00/0", Q, ACK);
        end
        m_q = 8'h00; m_ptr = 0; m_owner = 0;
    endtask

    task automatic test_random();
        logic [3:0]  mask;
        logic [31:0] d;
        int exp;
        int gap;
        int hold;
        bit abort;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            gap  = $urandom_range(0, 2);
            REQ  = 4'b0000;
            repeat (gap) begin
                tick();
                n_cmp++; if (BUSY !== 1'b0 || GNT !== 4'b0000 || OWNER !== 2'(m_owner)) begin
                    n_err++;
                    $display("FAIL rnd_idle[%0d]: got BUSY=%b GNT=%b OWNER=%0d required 0/0000/%0d", t, BUSY, GNT, OWNER, m_owner);
                end
            end
            mask  = 4'($urandom_range(1, 15));
            abort = ($urandom_range(0, 4) == 0);
            hold  = $urandom_range(0, 3);
            exp   = pick(mask, m_ptr);
            DATA  = $urandom;
            REQ   = mask;
            tick();
            n_cmp++; if (GNT !== onehot(exp) || OWNER !== 2'(exp) || BUSY !== 1'b1) begin
                n_err++;
                $display("FAIL rnd_grant[%0d]: got GNT=%b OWNER=%0d BUSY=%b required %b/%0d/1", t, GNT, OWNER, BUSY, onehot(exp), exp);
            end
            m_owner = exp;
            // Data changes after arbitration; the write must take the later value.
            d    = $urandom;
            DATA = d;
            if (abort) begin
                REQ = 4'b0000;
                tick();
                n_cmp++; if (GNT !== 4'b0000 || ACK !== 1'b0 || Q !== m_q || BUSY !== 1'b0) begin
                    n_err++;
                    $display("FAIL rnd_abort[%0d]: got GNT=%b ACK=%b Q=%h BUSY=%b required 0000/0/%h/0", t, GNT, ACK, Q, BUSY, m_q);
                end
                continue;
            end
            tick();
            m_q   = slice(d, exp);
            m_ptr = (exp + 1) % 4;
            n_cmp++; if (Q !== m_q || ACK !== 1'b1) begin
                n_err++;
                $display("FAIL rnd_write[%0d]: got Q=%h ACK=%b required %h/1", t, Q, ACK, m_q);
            end
            DATA = $urandom;
            tick();
            n_cmp++; if (ACK !== 1'b0 || GNT !== 4'b0000 || BUSY !== 1'b1) begin
                n_err++;
                $display("FAIL rnd_post_write[%0d]: got ACK=%b GNT=%b BUSY=%b required 0/0000/1", t, ACK, GNT, BUSY);
            end
            repeat (hold) begin
                tick();
                n_cmp++; if (GNT !== 4'b0000 || BUSY !== 1'b1 || Q !== m_q) begin
                    n_err++;
                    $display("FAIL rnd_hold[%0d]: got GNT=%b BUSY=%b Q=%h required 0000/1/%h", t, GNT, BUSY, Q, m_q);
                end
            end
            REQ = mask & ~onehot(exp);
            tick();
            n_cmp++; if (BUSY !== 1'b0 || GNT !== 4'b0000) begin
                n_err++;
                $display("FAIL rnd_release[%0d]: got BUSY=%b GNT=%b required 0/0000", t, BUSY, GNT);
            end
        end
        REQ = 4'b0000;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        prev_ack = 1'b0;
        RST      = 1'b1;
        REQ      = '0;
        DATA     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_hold_release();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
